tik_tac_toe_game: RTL and testbench

Two-party tic-tac-toe engine: a human player and an external computer agent alternately place marks on a 3x3 board.
- Holds the board state, rejects illegal moves and sequences turns with a small FSM.
- Detects a win or a full board and exposes every cell plus the winner code.
- Top-level game block; the board outputs drive LEDs or a display.

---
 rtl/tik_tac_toe_pkg.sv | 28 ++
 rtl/nospace_decetor.sv | 20 ++
 rtl/position_registers.sv | 32 +++
 rtl/tik_tac_toe_game.sv | 143 ++++++++++++++
 tb/tb_tik_tac_toe_game.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/tik_tac_toe_pkg.sv
// Shared definitions for the tic-tac-toe engine: cell codes, FSM states and
// the 4-bit position decoder.
package tik_tac_toe_pkg;

  localparam int unsigned NUM_CELLS = 9;

  localparam logic [1:0] EMPTY  = 2'b00;
  localparam logic [1:0] PLAYER = 2'b01;
  localparam logic [1:0] COMP   = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StPlyr,
    StComp,
    StGameOver
  } state_e;

  // One-hot cell enable; codes 9..15 select nothing.
  function automatic logic [NUM_CELLS-1:0] pos_decode(input logic [3:0] code);
    logic [NUM_CELLS-1:0] hot;
    hot = '0;
    if (code < 4'd9) begin
      hot[code] = 1'b1;
    end
    return hot;
  endfunction

endpackage

// File: rtl/nospace_decetor.sv
// Flags a completely filled board.
module nospace_decetor
  import tik_tac_toe_pkg::*;
(
  input  logic [NUM_CELLS-1:0][1:0] cells,
  output logic                      no_space
);

  logic [NUM_CELLS-1:0] occupied;

  always_comb begin
    occupied = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      occupied[i] = (cells[i] != EMPTY);
    end
  end

  assign no_space = &occupied;

endmodule

// File: rtl/position_registers.sv
// Nine 2-bit board cells. A write lands only when the move is legal; cells are
// cleared only by reset.
module position_registers
  import tik_tac_toe_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      illegal,
  input  logic [NUM_CELLS-1:0]      plyr_en,
  input  logic [NUM_CELLS-1:0]      comp_en,
  output logic [NUM_CELLS-1:0][1:0] cells
);

  logic [NUM_CELLS-1:0][1:0] cells_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cells_q <= '0;
    end else if (!illegal) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        if (plyr_en[i]) begin
          cells_q[i] <= PLAYER;
        end else if (comp_en[i]) begin
          cells_q[i] <= COMP;
        end
      end
    end
  end

  assign cells = cells_q;

endmodule

// File: rtl/tik_tac_toe_game.sv
// Tic-tac-toe engine: human vs external computer agent, turn sequencing,
// illegal-move rejection and win/draw detection.
module tik_tac_toe_game
  import tik_tac_toe_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       play,
  input  logic       pc,
  input  logic [3:0] comp_pos,
  input  logic [3:0] plyr_pos,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic [1:0] who
);

  state_e state_q, state_d;

  logic [NUM_CELLS-1:0][1:0] cells;
  logic [NUM_CELLS-1:0]      occupied;
  logic [NUM_CELLS-1:0]      plyr_en, comp_en;
  logic [7:0][1:0]           line_owner;
  logic                      illegal, win, no_space, game_end;

  function automatic logic [1:0] owner(input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] c);
    return (a != EMPTY && a == b && a == c) ? a : EMPTY;
  endfunction

  function automatic logic bad_move(input logic [3:0] code,
                                    input logic [NUM_CELLS-1:0] occ);
    logic [NUM_CELLS-1:0] hot;
    hot = pos_decode(code);
    return (hot == '0) || ((hot & occ) != '0);
  endfunction

  always_comb begin
    occupied = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      occupied[i] = (cells[i] != EMPTY);
    end
  end

  assign line_owner[0] = owner(cells[0], cells[1], cells[2]);
  assign line_owner[1] = owner(cells[3], cells[4], cells[5]);
  assign line_owner[2] = owner(cells[6], cells[7], cells[8]);
  assign line_owner[3] = owner(cells[0], cells[3], cells[6]);
  assign line_owner[4] = owner(cells[1], cells[4], cells[7]);
  assign line_owner[5] = owner(cells[2], cells[5], cells[8]);
  assign line_owner[6] = owner(cells[0], cells[4], cells[8]);
  assign line_owner[7] = owner(cells[2], cells[4], cells[6]);

  // First winning line wins; legal play never lets both marks complete a line.
  always_comb begin
    who = EMPTY;
    for (int i = 0; i < 8; i++) begin
      if (who == EMPTY) begin
        who = line_owner[i];
      end
    end
  end

  assign win      = (who != EMPTY);
  assign game_end = win | no_space;

  // Only the mover enabled by the current state is checked.
  always_comb begin
    illegal = 1'b0;
    unique case (state_q)
      StPlyr:  illegal = bad_move(plyr_pos, occupied);
      StComp:  illegal = bad_move(comp_pos, occupied);
      default: illegal = 1'b0;
    endcase
  end

  assign plyr_en = (state_q == StPlyr) ? pos_decode(plyr_pos) : '0;
  assign comp_en = (state_q == StComp && pc && !game_end) ? pos_decode(comp_pos) : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (game_end) begin
          state_d = StGameOver;
        end else if (play) begin
          state_d = StPlyr;
        end
      end
      StPlyr: begin
        state_d = illegal ? StIdle : StComp;
      end
      StComp: begin
        if (game_end) begin
          state_d = StGameOver;
        end else if (pc && !illegal) begin
          state_d = StIdle;
        end
      end
      StGameOver: state_d = StGameOver;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  position_registers u_position_registers (
    .clk     (clk),
    .reset   (reset),
    .illegal (illegal),
    .plyr_en (plyr_en),
    .comp_en (comp_en),
    .cells   (cells)
  );

  nospace_decetor u_nospace_decetor (
    .cells    (cells),
    .no_space (no_space)
  );

  assign pos1 = cells[0];
  assign pos2 = cells[1];
  assign pos3 = cells[2];
  assign pos4 = cells[3];
  assign pos5 = cells[4];
  assign pos6 = cells[5];
  assign pos7 = cells[6];
  assign pos8 = cells[7];
  assign pos9 = cells[8];

endmodule

// File: tb/tb_tik_tac_toe_game.sv
// Directed bench for tik_tac_toe_game: legal/illegal moves, wins, draw and
// asynchronous reset, against hand-computed board images.
module tb_tik_tac_toe_game;

  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] C = 2'b10;

  logic       clk = 1'b0;
  logic       reset, play, pc;
  logic [3:0] comp_pos, plyr_pos;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who;

  logic [8:0][1:0] exp_b;
  logic [17:0]     board;
  int              n_vec = 0;
  int              n_err = 0;

  always #5 clk = ~clk;

  assign board = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

  tik_tac_toe_game dut (
    .clk      (clk),
    .reset    (reset),
    .play     (play),
    .pc       (pc),
    .comp_pos (comp_pos),
    .plyr_pos (plyr_pos),
    .pos1     (pos1),
    .pos2     (pos2),
    .pos3     (pos3),
    .pos4     (pos4),
    .pos5     (pos5),
    .pos6     (pos6),
    .pos7     (pos7),
    .pos8     (pos8),
    .pos9     (pos9),
    .who      (who)
  );

  task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] want_who);
    check_eq({tag, ":board"}, board, exp_b);
    check_eq({tag, ":who"}, 18'(who), 18'(want_who));
  endtask

  // Called at a negedge; returns at the negedge after the PLYR-state edge.
  task automatic plyr_move(input int p);
    plyr_pos = 4'(p);
    play     = 1'b1;
    @(negedge clk);
    play     = 1'b0;
    @(negedge clk);
  endtask

  task automatic comp_move(input int p);
    comp_pos = 4'(p);
    pc       = 1'b1;
    @(negedge clk);
    pc       = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 exp_b = '0;
    check_all(tag, 2'b00);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int pm[5] = '{0, 2, 3, 7, 8};
  int cm[4] = '{1, 4, 5, 6};

  initial begin
    reset = 1'b1; play = 1'b0; pc = 1'b0; comp_pos = '0; plyr_pos = '0;
    exp_b = '0;
    repeat (10) @(negedge clk);
    check_all("reset", 2'b00);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_all("idle_hold", 2'b00);

    // Game 1: player wins on the top row, with illegal moves along the way
    plyr_move(0);  exp_b[0] = P;  check_all("p0", 2'b00);
    repeat (3) @(negedge clk);    check_all("comp_wait", 2'b00);
    comp_move(4);  exp_b[4] = C;  check_all("c4", 2'b00);
    plyr_move(4);                 check_all("p_occupied", 2'b00);
    comp_move(3);                 check_all("idle_ignores_pc", 2'b00);
    plyr_move(12);                check_all("p_code12", 2'b00);
    comp_move(3);                 check_all("idle_ignores_pc2", 2'b00);
    plyr_move(1);  exp_b[1] = P;  check_all("p1", 2'b00);
    comp_move(0);                 check_all("c_occupied", 2'b00);
    comp_move(13);                check_all("c_code13", 2'b00);
    comp_move(3);  exp_b[3] = C;  check_all("c3", 2'b00);
    plyr_move(2);  exp_b[2] = P;  check_all("p2_win", P);
    comp_move(6);                 check_all("c_after_win", P);
    plyr_move(6);
    comp_move(7);                 check_all("frozen", P);

    async_reset("async_reset_1");

    // Game 2: partial game, async reset mid-game, then a full draw
    plyr_move(0);  exp_b[0] = P;
    comp_move(1);  exp_b[1] = C;  check_all("partial", 2'b00);
    async_reset("async_reset_mid");
    for (int i = 0; i < 5; i++) begin
      plyr_move(pm[i]);
      exp_b[pm[i]] = P;
      if (i < 4) begin
        comp_move(cm[i]);
        exp_b[cm[i]] = C;
      end
    end
    check_all("draw", 2'b00);
    plyr_move(4);
    comp_move(4);                 check_all("draw_frozen", 2'b00);

    async_reset("async_reset_2");

    // Game 3: computer wins on the anti-diagonal
    plyr_move(0);  exp_b[0] = P;
    comp_move(2);  exp_b[2] = C;
    plyr_move(1);  exp_b[1] = P;
    comp_move(4);  exp_b[4] = C;
    plyr_move(7);  exp_b[7] = P;  check_all("pre_cwin", 2'b00);
    comp_move(6);  exp_b[6] = C;  check_all("c_win", C);
    plyr_move(8);                 check_all("cwin_frozen", C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
